// File: rtl/taiga_config.sv
// Build-time configuration for the fetch/decode front end.
package taiga_config;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;
endpackage

// File: rtl/taiga_types.sv
// Shared types for the fetch instruction queue.
package taiga_types;
    localparam int unsigned FETCH_QUEUE_DEPTH = taiga_config::FETCH_QUEUE_DEPTH;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_queue_entry_t;
endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrapping ring pointer with increment and synchronous clear.
module fetch_queue_ptr #(
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);
    // Natural overflow gives modulo-DEPTH wrap because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + PTR_W'(1);
    end
endmodule

// File: rtl/fetch_instruction_queue.sv
// In-order queue between fetch and decode: allocate on request, fill on return, pop to decode.
module fetch_instruction_queue
    import taiga_types::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gc_fetch_flush,
    input  logic        branch_flush,
    input  logic        pc_id_assigned,
    input  logic [31:0] if_pc,
    input  logic        fetch_complete,
    input  logic [31:0] fetch_instruction,
    input  logic        fetch_address_valid,
    output logic        pc_id_available,
    output logic        decode_valid,
    output logic [31:0] decode_pc,
    output logic [31:0] decode_instruction,
    output logic        decode_fetch_fault,
    input  logic        decode_advance,
    output logic        spurious_fill
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_queue_entry_t entries [DEPTH];

    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] pop_ptr;
    logic [CNT_W-1:0] alloc_count;
    logic [CNT_W-1:0] fill_count;

    logic flush;
    logic alloc;
    logic fill;
    logic pop;
    logic bad_alloc;
    logic bad_fill;

    always_comb begin
        flush           = gc_fetch_flush | branch_flush;
        pc_id_available = (alloc_count < CNT_W'(DEPTH));
        decode_valid    = (fill_count != '0);
        alloc           = pc_id_assigned & pc_id_available & ~flush;
        // A same-cycle allocation counts as outstanding, so fill may land on it.
        fill            = fetch_complete & ~flush & ((alloc_count != fill_count) | alloc);
        pop             = decode_valid & decode_advance & ~flush;
        bad_alloc       = pc_id_assigned & ~pc_id_available & ~flush;
        bad_fill        = fetch_complete & ~fill & ~flush;
    end

    fetch_queue_ptr #(.PTR_W(PTR_W)) alloc_ptr_i (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (alloc),
        .ptr   (alloc_ptr)
    );

    fetch_queue_ptr #(.PTR_W(PTR_W)) fill_ptr_i (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (fill),
        .ptr   (fill_ptr)
    );

    fetch_queue_ptr #(.PTR_W(PTR_W)) pop_ptr_i (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (pop),
        .ptr   (pop_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alloc_count <= '0;
            fill_count  <= '0;
        end else begin
            alloc_count <= alloc_count + CNT_W'(alloc) - CNT_W'(pop);
            fill_count  <= fill_count + CNT_W'(fill) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            spurious_fill <= 1'b0;
        else if (bad_alloc || bad_fill)
            spurious_fill <= 1'b1;
    end

    // Storage is intentionally not reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (alloc)
            entries[alloc_ptr].pc <= if_pc;
        if (fill) begin
            entries[fill_ptr].instr <= fetch_instruction;
            entries[fill_ptr].fault <= ~fetch_address_valid;
        end
    end

    always_comb begin
        decode_pc          = entries[pop_ptr].pc;
        decode_instruction = entries[pop_ptr].instr;
        decode_fetch_fault = entries[pop_ptr].fault;
    end
endmodule

// File: tb/tb_fetch_instruction_queue.sv
// Directed bench for fetch_instruction_queue; inputs change 1ns after each rising edge.
module tb_fetch_instruction_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        gc_fetch_flush;
    logic        branch_flush;
    logic        pc_id_assigned;
    logic [31:0] if_pc;
    logic        fetch_complete;
    logic [31:0] fetch_instruction;
    logic        fetch_address_valid;
    logic        pc_id_available;
    logic        decode_valid;
    logic [31:0] decode_pc;
    logic [31:0] decode_instruction;
    logic        decode_fetch_fault;
    logic        decode_advance;
    logic        spurious_fill;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    fetch_instruction_queue #(.DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .gc_fetch_flush      (gc_fetch_flush),
        .branch_flush        (branch_flush),
        .pc_id_assigned      (pc_id_assigned),
        .if_pc               (if_pc),
        .fetch_complete      (fetch_complete),
        .fetch_instruction   (fetch_instruction),
        .fetch_address_valid (fetch_address_valid),
        .pc_id_available     (pc_id_available),
        .decode_valid        (decode_valid),
        .decode_pc           (decode_pc),
        .decode_instruction  (decode_instruction),
        .decode_fetch_fault  (decode_fetch_fault),
        .decode_advance      (decode_advance),
        .spurious_fill       (spurious_fill)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gc_fetch_flush      = 1'b0;
        branch_flush        = 1'b0;
        pc_id_assigned      = 1'b0;
        if_pc               = '0;
        fetch_complete      = 1'b0;
        fetch_instruction   = '0;
        fetch_address_valid = 1'b1;
        decode_advance      = 1'b0;
    endtask

    task automatic do_alloc(input logic [31:0] pc);
        pc_id_assigned = 1'b1;
        if_pc          = pc;
    endtask

    task automatic do_fill(input logic [31:0] ins, input logic addr_ok);
        fetch_complete      = 1'b1;
        fetch_instruction   = ins;
        fetch_address_valid = addr_ok;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_avail", 32'(pc_id_available), 32'd1);
        check("rst_valid", 32'(decode_valid), 32'd0);
        check("rst_spur", 32'(spurious_fill), 32'd0);

        // Three requests, each filled two cycles later, decode always advancing.
        idle(); decode_advance = 1'b1; do_alloc(32'h8000_0000);
        tick();
        idle(); decode_advance = 1'b1; do_alloc(32'h8000_0004);
        tick();
        idle(); decode_advance = 1'b1; do_alloc(32'h8000_0008); do_fill(32'h0000_0013, 1'b1);
        check("seq_nofill_valid", 32'(decode_valid), 32'd0);
        tick();
        idle(); decode_advance = 1'b1; do_fill(32'h0010_0093, 1'b1);
        check("seq0_valid", 32'(decode_valid), 32'd1);
        check("seq0_pc", decode_pc, 32'h8000_0000);
        check("seq0_instr", decode_instruction, 32'h0000_0013);
        check("seq0_fault", 32'(decode_fetch_fault), 32'd0);
        tick();
        idle(); decode_advance = 1'b1; do_fill(32'h0020_0113, 1'b1);
        check("seq1_pc", decode_pc, 32'h8000_0004);
        check("seq1_instr", decode_instruction, 32'h0010_0093);
        tick();
        idle(); decode_advance = 1'b1;
        check("seq2_valid", 32'(decode_valid), 32'd1);
        check("seq2_pc", decode_pc, 32'h8000_0008);
        check("seq2_instr", decode_instruction, 32'h0020_0113);
        tick();
        idle();
        check("seq_empty", 32'(decode_valid), 32'd0);
        check("seq_spur", 32'(spurious_fill), 32'd0);

        // Fill to capacity, then one pop frees a slot on the following cycle.
        for (int i = 0; i < 4; i++) begin
            idle(); do_alloc(32'h100 + 32'(i) * 4); do_fill(32'hA000 + 32'(i), 1'b1);
            if (i == 3) check("full_avail_before4", 32'(pc_id_available), 32'd1);
            tick();
        end
        idle();
        check("full_avail", 32'(pc_id_available), 32'd0);
        check("full_head", decode_pc, 32'h100);
        decode_advance = 1'b1;
        check("full_avail_popcycle", 32'(pc_id_available), 32'd0);
        tick();
        idle();
        check("full_avail_after_pop", 32'(pc_id_available), 32'd1);
        check("full_head_after_pop", decode_pc, 32'h104);
        check("full_instr_after_pop", decode_instruction, 32'hA001);
        gc_fetch_flush = 1'b1;
        tick();
        idle();
        check("full_flush_valid", 32'(decode_valid), 32'd0);

        // Build alloc_count=2, fill_count=1, then allocate+fill+pop together.
        do_alloc(32'h200); do_fill(32'hB200, 1'b1);
        tick();
        idle(); do_alloc(32'h204);
        tick();
        idle();
        check("mix_acount_pre", 32'(dut.alloc_count), 32'd2);
        check("mix_fcount_pre", 32'(dut.fill_count), 32'd1);
        do_alloc(32'h208); do_fill(32'hB204, 1'b1); decode_advance = 1'b1;
        check("mix_head_pre", decode_pc, 32'h200);
        tick();
        idle();
        check("mix_acount", 32'(dut.alloc_count), 32'd2);
        check("mix_fcount", 32'(dut.fill_count), 32'd1);
        check("mix_head", decode_pc, 32'h204);
        check("mix_instr", decode_instruction, 32'hB204);
        decode_advance = 1'b1; do_fill(32'hB208, 1'b1);
        tick();
        idle();
        check("mix_head2", decode_pc, 32'h208);
        check("mix_instr2", decode_instruction, 32'hB208);
        decode_advance = 1'b1;
        tick();
        idle();
        check("mix_drained", 32'(decode_valid), 32'd0);

        // Fetch fault from an unmapped address.
        do_alloc(32'h10); do_fill(32'hDEAD_BEEF, 1'b0);
        tick();
        idle();
        check("fault_flag", 32'(decode_fetch_fault), 32'd1);
        check("fault_pc", decode_pc, 32'h10);
        decode_advance = 1'b1;
        tick();
        idle();

        // Global flush with three entries (two filled) and a concurrent request.
        do_alloc(32'h300); do_fill(32'hC300, 1'b1);
        tick();
        idle(); do_alloc(32'h304); do_fill(32'hC304, 1'b1);
        tick();
        idle(); do_alloc(32'h308);
        tick();
        idle(); gc_fetch_flush = 1'b1; do_alloc(32'h30C);
        tick();
        idle();
        check("flush_valid", 32'(decode_valid), 32'd0);
        check("flush_avail", 32'(pc_id_available), 32'd1);
        check("flush_acount", 32'(dut.alloc_count), 32'd0);
        do_alloc(32'h8000_0100);
        tick();
        idle(); do_fill(32'h0000_ABCD, 1'b1);
        tick();
        idle();
        check("postflush_pc", decode_pc, 32'h8000_0100);
        check("postflush_instr", decode_instruction, 32'h0000_ABCD);
        // Branch flush clears a filled entry too.
        branch_flush = 1'b1;
        tick();
        idle();
        check("bflush_valid", 32'(decode_valid), 32'd0);
        check("spur_before", 32'(spurious_fill), 32'd0);

        // Completion with nothing outstanding.
        do_fill(32'h1234_5678, 1'b1);
        tick();
        idle();
        check("spur_valid", 32'(decode_valid), 32'd0);
        check("spur_set", 32'(spurious_fill), 32'd1);
        tick();
        tick();
        check("spur_sticky", 32'(spurious_fill), 32'd1);

        // Back-to-back allocate+fill+pop across several pointer wraps.
        for (int i = 0; i <= 10; i++) begin
            idle();
            decode_advance = 1'b1;
            if (i < 10) begin
                do_alloc(32'h400 + 32'(i) * 4);
                do_fill(32'h1000 + 32'(i), 1'b1);
            end
            if (i == 0) begin
                check("wrap_start_valid", 32'(decode_valid), 32'd0);
            end else begin
                check("wrap_valid", 32'(decode_valid), 32'd1);
                check("wrap_pc", decode_pc, 32'h400 + 32'(i - 1) * 4);
                check("wrap_instr", decode_instruction, 32'h1000 + 32'(i - 1));
            end
            tick();
        end
        idle();
        check("wrap_empty", 32'(decode_valid), 32'd0);
        check("wrap_spur_still", 32'(spurious_fill), 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_spur_clear", 32'(spurious_fill), 32'd0);
        check("rst2_avail", 32'(pc_id_available), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_instruction_queue.md
Name: fetch_instruction_queue

Overview:
- Sits between fetch and decode.
- Allocates an entry holding the fetch PC when fetch issues a request (pc_id_assigned).
- Fills the oldest unfilled entry with the instruction word when fetch reports completion (fetch_complete).
- Presents filled entries to decode in program order with a valid/advance handshake, and drives pc_id_available back to fetch as the credit signal.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- gc_fetch_flush  in  1  global-control flush; discards all entries.
- branch_flush  in  1  mispredict flush; discards all entries.
- pc_id_assigned  in  1  fetch issued a request this cycle.
- if_pc  in  32  PC of the request issued this cycle.
- fetch_complete  in  1  instruction data returned this cycle.
- fetch_instruction  in  32  returned instruction word.
- fetch_address_valid  in  1  0 = address matched no memory sub-unit.
- pc_id_available  out  1  an entry is free for allocation.
- decode_valid  out  1  head entry allocated and filled.
- decode_pc  out  32  head PC.
- decode_instruction  out  32  head instruction.
- decode_fetch_fault  out  1  head fetched from an invalid address (inverse of fetch_address_valid).
- decode_advance  in  1  decode consumes the head; ignored when decode_valid=0.
- spurious_fill  out  1  sticky error flag.

Behaviour:
- Storage:
  - Circular arrays pc[DEPTH], instr[DEPTH], fault[DEPTH].
  - Pointers alloc_ptr, fill_ptr, pop_ptr, each PTR_W bits, wrapping modulo DEPTH.
  - Counters alloc_count and fill_count, each 0..DEPTH, PTR_W+1 bits.
- Invariant: pop_ptr ≤ fill_ptr ≤ alloc_ptr in ring order, so fill_count ≤ alloc_count ≤ DEPTH.
- Allocate, when pc_id_assigned=1:
  - Write pc[alloc_ptr] ← if_pc.
  - Advance alloc_ptr; increment alloc_count.
- Fill, when fetch_complete=1 and alloc_count > fill_count (counting the same-cycle allocation):
  - Write instr[fill_ptr] ← fetch_instruction and fault[fill_ptr] ← ~fetch_address_valid.
  - Advance fill_ptr; increment fill_count.
  - A fill is allowed in the same cycle as the allocation of the same entry; the entry becomes visible to decode next cycle.
- Fill with no outstanding allocation: the data is dropped, spurious_fill is set, and it stays set until rst.
- Pop, when decode_valid & decode_advance:
  - Advance pop_ptr; decrement both counters.
- Any combination of allocate, fill and pop may occur in one cycle. Counters use the net change:
  - alloc_count += alloc − pop.
  - fill_count += fill − pop.
- pc_id_available = (alloc_count < DEPTH):
  - Depends on registered state only, so it has no combinational path from decode_advance or fetch_complete.
  - A slot freed by a pop becomes available the following cycle.
- pc_id_assigned while pc_id_available=0 is a protocol violation. The allocation is dropped and spurious_fill is set.
- Outputs:
  - decode_valid = (fill_count != 0).
  - decode_pc, decode_instruction and decode_fetch_fault read combinationally at pop_ptr.
  - Output data is don't-care while decode_valid=0.
- Flush, when gc_fetch_flush | branch_flush:
  - All pointers and counters are cleared to 0 next cycle.
  - Allocate, fill and pop in the flush cycle are all ignored.
  - Fetch guarantees no data_valid for requests squashed by a flush, so no post-flush stale fills arrive.
- Reset values:
  - All pointers and counters 0; spurious_fill 0.
  - pc_id_available=1 and decode_valid=0 from the first cycle after rst.
  - Array contents are not reset.
- Latency: a fill at cycle N gives decode_valid at N+1. There is no bypass from fetch to decode.

Decomposition:
- The shared package (taiga_types) holds:
  - typedef fetch_queue_entry_t {pc[31:0], instr[31:0], fault}.
  - Localparam FETCH_QUEUE_DEPTH, default 4, referenced from taiga_config.
- One natural sub-module, fetch_queue_ptr: a wrapping pointer with an increment input and a synchronous clear. It is instantiated three times.

Test Plan:
- Reset, then allocate PCs 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, with fills 2 cycles later (instructions 0x00000013, 0x00100093, 0x00200113) and decode_advance=1 throughout -> decode sees the three pairs in order, each one cycle after its fill; spurious_fill=0.
- 4 allocations with no pops -> pc_id_available=0 on the cycle after the 4th. Then one pop -> pc_id_available=1 exactly one cycle after the pop.
- Same-cycle allocate + fill + pop with alloc_count=2, fill_count=1 -> alloc_count stays 2, fill_count stays 1, pop_ptr advances by 1; the head PC follows the previously allocated order.
- Fill with fetch_address_valid=0 at PC 0x00000010 -> decode_fetch_fault=1 with decode_pc=0x00000010.
- gc_fetch_flush with 3 entries (2 filled) plus a concurrent pc_id_assigned -> next cycle decode_valid=0 and pc_id_available=1. A new allocation of 0x80000100 then fill is the next decoded entry.
- fetch_complete asserted with an empty queue -> no decode_valid; spurious_fill=1 and it remains set until rst.
- Wrap-around: 10 back-to-back allocate/fill/pop pairs with DEPTH=4 -> all 10 PCs emerge in order and no loss occurs across pointer wrap.
